// File: rtl/signed_serial_subtractor_if.sv
// Operand/result bundle for signed_serial_subtractor; ovf only exists when
// SIGNEDSUB_OVF_EN is defined. dbg_state mirrors the FSM state for observation.
interface signed_serial_subtractor_if #(
    parameter int size = 4
);
    // Handshake: start is a request sampled only while idle; busy is high for
    // the size+1 serial cycles; done pulses one cycle when d is newly valid.
    logic            start;
    logic [size-1:0] x;
    logic [size-1:0] y;
    logic [7:0]      d;
    logic            busy;
    logic            done;
    logic [1:0]      dbg_state;
`ifdef SIGNEDSUB_OVF_EN
    logic            ovf;
`endif

    modport master (
        output start, x, y,
        input  d, busy, done, dbg_state
`ifdef SIGNEDSUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, x, y,
        output d, busy, done, dbg_state
`ifdef SIGNEDSUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/signed_serial_subtractor.sv
// Bit-serial signed subtractor: d = x - y over size+1 cycles, LSB first.
// Optional overflow flag (result outside size-bit range) under SIGNEDSUB_OVF_EN.
module signed_serial_subtractor #(
    parameter int size = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    signed_serial_subtractor_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    logic [size:0] r_xe;
    logic [size:0] r_ye;
    logic [size:0] r_acc;
    logic [2:0]    r_cnt;
    logic          r_carry;
    logic [7:0]    r_d;
    logic          r_busy;
    logic          r_done;
`ifdef SIGNEDSUB_OVF_EN
    logic          r_ovf;
`endif

    logic               w_a;
    logic               w_b;
    logic               w_bit;
    logic               w_cout;
    logic [size:0]      w_res;
    logic signed [size:0] w_res_s;
    logic [7:0]         w_d;

    // x + ~y + 1: the carry register starts at 1 to supply the +1.
    assign w_a     = r_xe[0];
    assign w_b     = ~r_ye[0];
    assign w_bit   = w_a ^ w_b ^ r_carry;
    assign w_cout  = (w_a & w_b) | (w_a & r_carry) | (w_b & r_carry);
    assign w_res   = {w_bit, r_acc[size:1]};
    assign w_res_s = w_res;
    assign w_d     = 8'(w_res_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_xe    <= '0;
            r_ye    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_d     <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SIGNEDSUB_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_xe    <= {bus.x[size-1], bus.x};
                        r_ye    <= {bus.y[size-1], bus.y};
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_carry <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_xe    <= r_xe >> 1;
                    r_ye    <= r_ye >> 1;
                    r_acc   <= w_res;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 3'd1;
                    // Final bit: publish the whole result at once so d never shows a partial value.
                    if (r_cnt == 3'(size)) begin
                        r_d     <= w_d;
`ifdef SIGNEDSUB_OVF_EN
                        r_ovf   <= w_bit ^ r_acc[size];
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.d         = r_d;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;
`ifdef SIGNEDSUB_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_signed_serial_subtractor.sv
// Directed bench for signed_serial_subtractor (size=4); ovf checks only when
// SIGNEDSUB_OVF_EN is defined.
module tb_signed_serial_subtractor;
    localparam int SIZE = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [7:0] last_d;

    signed_serial_subtractor_if #(.size(SIZE)) bus ();

    signed_serial_subtractor #(.size(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts an operation in the current (idle) cycle, checks the busy window,
    // the done pulse and the result, and returns at the negedge after done falls.
    task automatic run_op(input string tag, input logic [3:0] xv, input logic [3:0] yv,
                          input logic [7:0] exp_d, input logic exp_ovf);
        bus.x     = xv;
        bus.y     = yv;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.x     = ~xv;
        bus.y     = ~yv;
        for (int i = 0; i < SIZE + 1; i++) begin
            check({tag, "_busy"}, {7'd0, bus.busy}, 8'd1);
            check({tag, "_nodone"}, {7'd0, bus.done}, 8'd0);
            check({tag, "_dhold"}, bus.d, last_d);
            @(negedge clk);
        end
        check({tag, "_done"}, {7'd0, bus.done}, 8'd1);
        check({tag, "_busy_lo"}, {7'd0, bus.busy}, 8'd0);
        check({tag, "_d"}, bus.d, exp_d);
`ifdef SIGNEDSUB_OVF_EN
        check({tag, "_ovf"}, {7'd0, bus.ovf}, {7'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) n_fail++;
`endif
        @(negedge clk);
        check({tag, "_done_lo"}, {7'd0, bus.done}, 8'd0);
        check({tag, "_idle"}, {6'd0, bus.dbg_state}, 8'd0);
        last_d = exp_d;
    endtask

    initial begin
        int done_cnt;
        n_tests   = 0;
        n_fail    = 0;
        last_d    = 8'h00;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_d", bus.d, 8'h00);
        check("rst_busy", {7'd0, bus.busy}, 8'd0);
        check("rst_done", {7'd0, bus.done}, 8'd0);
        check("rst_state", {6'd0, bus.dbg_state}, 8'd0);
`ifdef SIGNEDSUB_OVF_EN
        check("rst_ovf", {7'd0, bus.ovf}, 8'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("sub_3_5", 4'h3, 4'h5, 8'hFE, 1'b0);
        run_op("sub_m8_7", 4'h8, 4'h7, 8'hF1, 1'b1);
        run_op("sub_7_m8", 4'h7, 4'h8, 8'h0F, 1'b1);

        // Idle with start low: result must hold even as x/y move.
        bus.x = 4'h5;
        bus.y = 4'h1;
        repeat (3) @(negedge clk);
        check("idle_hold_d", bus.d, 8'h0F);
        check("idle_busy", {7'd0, bus.busy}, 8'd0);
        check("idle_done", {7'd0, bus.done}, 8'd0);

        // Back-to-back: second start is in the idle cycle right after DONE.
        run_op("sub_0_0", 4'h0, 4'h0, 8'h00, 1'b0);
        run_op("sub_m1_m1", 4'hF, 4'hF, 8'h00, 1'b0);
        run_op("sub_m8_1", 4'h8, 4'h1, 8'hF7, 1'b1);
        run_op("sub_1_m1", 4'h1, 4'hF, 8'h02, 1'b0);

        // Re-pulse start with new operands during SHIFT: must be ignored.
        bus.x     = 4'h3;
        bus.y     = 4'h5;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.x    = 4'h7;
        bus.y    = 4'h8;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) bus.start = 1'b0;
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                check("repulse_d", bus.d, 8'hFE);
            end
        end
        check("repulse_done_cnt", 8'(done_cnt), 8'd1);
        check("repulse_idle", {6'd0, bus.dbg_state}, 8'd0);
        last_d = 8'hFE;

        // Reset during the 3rd SHIFT cycle aborts without a done pulse.
        bus.x     = 4'h3;
        bus.y     = 4'h5;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", {7'd0, bus.busy}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_d", bus.d, 8'h00);
        check("midrst_busy", {7'd0, bus.busy}, 8'd0);
        check("midrst_done", {7'd0, bus.done}, 8'd0);
        check("midrst_state", {6'd0, bus.dbg_state}, 8'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("midrst_no_done", 8'(done_cnt), 8'd0);
        last_d = 8'h00;
        run_op("sub_2_m2", 4'h2, 4'hE, 8'h04, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/signed_serial_subtractor.md
SIGNED_SERIAL_SUBTRACTOR -- requirements
Module: signed_serial_subtractor

Interface
REQ-001 Parameter: size, default 4, operand width in bits; legal range 2..7.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 Port: x  input  size  signed two's-complement minuend.
REQ-006 Port: y  input  size  signed two's-complement subtrahend.
REQ-007 Port: d  output  8  signed difference x - y, sign-extended to 8 bits.
REQ-008 Port: busy  output  1  high while a subtraction is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; d is newly valid.
REQ-010 Port: ovf  output  1  present only when SIGNEDSUB_OVF_EN is defined (see Configuration).
REQ-011 Design has exactly one clock and one reset: clk and rst_n, asynchronous, active-low.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; busy = (state == SHIFT); done = (state == DONE).
REQ-013 IDLE with start=1 at an edge: latch x and y, each sign-extended to size+1 bits; clear bit counter; set carry register to 1; go to SHIFT.
REQ-014 IDLE with start=0: hold state; d and all other registers unchanged.
REQ-015 SHIFT: one result bit per cycle, LSB first; bit i = xe[i] XOR ~ye[i] XOR carry; next carry = full-adder carry-out of the same three inputs.
REQ-016 SHIFT lasts exactly size+1 cycles (bits 0..size); the edge that computes bit size moves the FSM to DONE.
REQ-017 On that same edge, d is loaded with the (size+1)-bit result in d[size:0] and d[7:size+1] = result bit size (sign extension).
REQ-018 DONE lasts exactly one cycle, then returns to IDLE unconditionally.
REQ-019 Latency: start sampled at edge 0 -> d valid and done high after edge size+1 -> done low after edge size+2.
REQ-020 start in SHIFT or DONE is ignored; x and y changes after edge 0 do not affect the result in progress.
REQ-021 d holds its last result until the next DONE entry; a partial result is never visible on d.
REQ-022 Result is exact: x - y always fits in size+1 signed bits, so d never wraps.
REQ-023 Back-to-back operation: start high during the cycle after DONE is accepted at the next edge.

Reset
REQ-024 rst_n low forces, without waiting for clk: state=IDLE, d=8'h00, busy=0, done=0, carry=0, counter=0, ovf=0 if present.
REQ-025 rst_n asserted mid-SHIFT aborts the operation; no done pulse follows; the first start after rst_n deassertion begins a fresh operation.

Configuration
REQ-026 Macro SIGNEDSUB_OVF_EN defined: port ovf exists; it is loaded on the same edge as d, and is 1 iff the result is outside the size-bit signed range (result bit size != result bit size-1). It holds until the next load.
REQ-027 Macro SIGNEDSUB_OVF_EN undefined: no ovf port, no ovf logic; all other behaviour identical.

Verification (size=4, SIGNEDSUB_OVF_EN defined)
REQ-028 x=4'h3, y=4'h5, start pulse -> busy high 5 cycles, then done for 1 cycle; d=8'hFE, ovf=0.
REQ-029 x=4'h8 (-8), y=4'h7 -> d=8'hF1 (-15), ovf=1; x=4'h7, y=4'h8 -> d=8'h0F (+15), ovf=1.
REQ-030 x=4'h0, y=4'h0 -> d=8'h00, ovf=0; then immediately x=4'hF, y=4'hF with start in the cycle after done -> d=8'h00, done after another 5 busy cycles.
REQ-031 start re-pulsed with new x/y during SHIFT -> ignored; the first result is reported; exactly one done pulse.
REQ-032 rst_n pulsed low during the 3rd SHIFT cycle -> outputs reset immediately; no done pulse; a following start with x=4'h2, y=4'hE -> d=8'h04.
